// File: rtl/fifo_arb_ctrl.sv
// 16x4 FIFO shared by two writers and one reader, one storage operation per cycle.
// Read/write alternate under contention; the two writers rotate by last granted writer.
module fifo_arb_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr0_req,
   input  logic [3:0] wr0_data,
   output logic       wr0_gnt,
   input  logic       wr1_req,
   input  logic [3:0] wr1_data,
   output logic       wr1_gnt,
   input  logic       rd_req,
   output logic       rd_gnt,
   output logic [3:0] data_out,
   output logic       data_valid,
   output logic       full,
   output logic       empty,
   output logic [4:0] count
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StWr0  = 2'd1;
   localparam logic [1:0] StWr1  = 2'd2;
   localparam logic [1:0] StRd   = 2'd3;

   logic [3:0] mem_q [16];
   logic [3:0] wr_ptr_q, rd_ptr_q;
   logic [4:0] count_q;
   logic [3:0] data_out_q;
   logic       data_valid_q;
   logic [1:0] last_op_q, last_op_d;
   logic       last_wr_q;

   logic       w0_elig, w1_elig, rd_elig;
   logic       rd_win, push, sel_wr1;
   logic [3:0] push_data;

   assign full       = (count_q == 5'd16);
   assign empty      = (count_q == 5'd0);
   assign count      = count_q;
   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;

   always_comb begin
      w0_elig = wr0_req && !full;
      w1_elig = wr1_req && !full;
      rd_elig = rd_req && !empty;
      // A read yields to writes only right after an idle or read cycle.
      rd_win  = rd_elig && (!(w0_elig || w1_elig) || last_op_q == StWr0 || last_op_q == StWr1);
      push    = (w0_elig || w1_elig) && !rd_win;
      sel_wr1 = (w0_elig && w1_elig) ? !last_wr_q : w1_elig;
      push_data = sel_wr1 ? wr1_data : wr0_data;
      wr0_gnt = push && !sel_wr1;
      wr1_gnt = push && sel_wr1;
      rd_gnt  = rd_win;
      last_op_d = StIdle;
      if (rd_win) begin
         last_op_d = StRd;
      end else if (push) begin
         last_op_d = sel_wr1 ? StWr1 : StWr0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q     <= 4'd0;
         rd_ptr_q     <= 4'd0;
         count_q      <= 5'd0;
         data_out_q   <= 4'd0;
         data_valid_q <= 1'b0;
         last_op_q    <= StIdle;
         last_wr_q    <= 1'b1;
      end else begin
         data_valid_q <= rd_win;
         last_op_q    <= last_op_d;
         if (push) begin
            wr_ptr_q  <= wr_ptr_q + 4'd1;
            last_wr_q <= sel_wr1;
            count_q   <= count_q + 5'd1;
         end else if (rd_win) begin
            count_q   <= count_q - 5'd1;
         end
         if (rd_win) begin
            rd_ptr_q   <= rd_ptr_q + 4'd1;
            data_out_q <= mem_q[rd_ptr_q];
         end
      end
   end

   // Storage is not reset; only the write is blocked during reset.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: tb/tb_fifo_arb_ctrl.sv
// Self-checking bench for fifo_arb_ctrl: directed vector table, corner sequences and
// randomized traffic compared against a queue-based reference model.
module tb_fifo_arb_ctrl;

   logic       clk;
   logic       rst;
   logic       wr0_req, wr1_req, rd_req;
   logic [3:0] wr0_data, wr1_data;
   logic       wr0_gnt, wr1_gnt, rd_gnt;
   logic [3:0] data_out;
   logic       data_valid, full, empty;
   logic [4:0] count;

   fifo_arb_ctrl dut (
      .clk(clk), .rst(rst),
      .wr0_req(wr0_req), .wr0_data(wr0_data), .wr0_gnt(wr0_gnt),
      .wr1_req(wr1_req), .wr1_data(wr1_data), .wr1_gnt(wr1_gnt),
      .rd_req(rd_req), .rd_gnt(rd_gnt),
      .data_out(data_out), .data_valid(data_valid),
      .full(full), .empty(empty), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: contents as a queue, plus arbitration history.
   localparam int OpIdle = 0, OpWr0 = 1, OpWr1 = 2, OpRd = 3;
   logic [3:0] m_q [$];
   int         m_last_op;
   bit         m_last_wr;
   logic [3:0] m_dout;
   bit         m_dv;

   // Outputs sampled mid-cycle by the last call of step().
   bit         s_g0, s_g1, s_gr, s_dv;
   logic [4:0] s_cnt;
   logic [3:0] s_dout;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_q.delete();
      m_last_op = OpIdle;
      m_last_wr = 1'b1;
      m_dout    = 4'd0;
      m_dv      = 1'b0;
   endtask

   task automatic predict(input bit w0r, input bit w1r, input bit rr,
                          output bit g0, output bit g1, output bit gr);
      bit f, e, w0, w1, r;
      f  = (m_q.size() == 16);
      e  = (m_q.size() == 0);
      w0 = w0r && !f;
      w1 = w1r && !f;
      r  = rr && !e;
      g0 = 0; g1 = 0; gr = 0;
      if (r && (!(w0 || w1) || m_last_op == OpWr0 || m_last_op == OpWr1)) gr = 1;
      else if (w0 && w1) begin
         g0 = (m_last_wr == 1'b1);
         g1 = !g0;
      end else begin
         g0 = w0;
         g1 = w1;
      end
   endtask

   // One clock cycle: drive, check at the falling edge, then advance the model.
   task automatic step(input bit r, input bit w0r, input logic [3:0] w0d,
                       input bit w1r, input logic [3:0] w1d, input bit rr);
      bit g0, g1, gr;
      rst = r; wr0_req = w0r; wr0_data = w0d; wr1_req = w1r; wr1_data = w1d; rd_req = rr;
      #4;
      predict(w0r, w1r, rr, g0, g1, gr);
      s_g0 = wr0_gnt; s_g1 = wr1_gnt; s_gr = rd_gnt; s_dv = data_valid;
      s_cnt = count; s_dout = data_out;
      chk("wr0_gnt", 32'(wr0_gnt), 32'(g0));
      chk("wr1_gnt", 32'(wr1_gnt), 32'(g1));
      chk("rd_gnt", 32'(rd_gnt), 32'(gr));
      chk("count", 32'(count), 32'(m_q.size()));
      chk("full", 32'(full), 32'(m_q.size() == 16));
      chk("empty", 32'(empty), 32'(m_q.size() == 0));
      chk("data_valid", 32'(data_valid), 32'(m_dv));
      chk("data_out", 32'(data_out), 32'(m_dout));
      @(posedge clk);
      if (r) m_reset();
      else begin
         m_dv = 1'b0;
         m_last_op = OpIdle;
         if (g0) begin m_q.push_back(w0d); m_last_wr = 1'b0; m_last_op = OpWr0; end
         if (g1) begin m_q.push_back(w1d); m_last_wr = 1'b1; m_last_op = OpWr1; end
         if (gr) begin m_dout = m_q.pop_front(); m_dv = 1'b1; m_last_op = OpRd; end
      end
      #1;
   endtask

   typedef struct {
      bit         r, w0r, w1r, rr;
      logic [3:0] w0d, w1d;
      bit         g0, g1, gr, dv;
      logic [4:0] cnt;
      logic [3:0] dout;
   } vec_t;

   function automatic vec_t mk(bit r, bit w0r, logic [3:0] w0d, bit w1r, logic [3:0] w1d,
                               bit rr, bit g0, bit g1, bit gr, logic [4:0] cnt, bit dv,
                               logic [3:0] dout);
      vec_t v;
      v.r = r; v.w0r = w0r; v.w0d = w0d; v.w1r = w1r; v.w1d = w1d; v.rr = rr;
      v.g0 = g0; v.g1 = g1; v.gr = gr; v.cnt = cnt; v.dv = dv; v.dout = dout;
      return v;
   endfunction

   vec_t vecs [20];

   initial begin
      // Post-reset arbitration, pops, empty read, then contention from count 4.
      vecs[0]  = mk(0, 1, 4'h3, 1, 4'h5, 0,  1, 0, 0, 0, 0, 4'h0);
      vecs[1]  = mk(0, 1, 4'h3, 1, 4'h5, 0,  0, 1, 0, 1, 0, 4'h0);
      vecs[2]  = mk(0, 0, 4'h0, 0, 4'h0, 0,  0, 0, 0, 2, 0, 4'h0);
      vecs[3]  = mk(0, 0, 4'h0, 0, 4'h0, 1,  0, 0, 1, 2, 0, 4'h0);
      vecs[4]  = mk(0, 0, 4'h0, 0, 4'h0, 1,  0, 0, 1, 1, 1, 4'h3);
      vecs[5]  = mk(0, 0, 4'h0, 0, 4'h0, 0,  0, 0, 0, 0, 1, 4'h5);
      vecs[6]  = mk(0, 0, 4'h0, 0, 4'h0, 1,  0, 0, 0, 0, 0, 4'h5);
      vecs[7]  = mk(0, 0, 4'h0, 0, 4'h0, 0,  0, 0, 0, 0, 0, 4'h5);
      vecs[8]  = mk(0, 1, 4'hA, 0, 4'h0, 0,  1, 0, 0, 0, 0, 4'h5);
      vecs[9]  = mk(0, 1, 4'hB, 0, 4'h0, 0,  1, 0, 0, 1, 0, 4'h5);
      vecs[10] = mk(0, 1, 4'hC, 0, 4'h0, 0,  1, 0, 0, 2, 0, 4'h5);
      vecs[11] = mk(0, 1, 4'hD, 0, 4'h0, 0,  1, 0, 0, 3, 0, 4'h5);
      vecs[12] = mk(0, 0, 4'h0, 0, 4'h0, 0,  0, 0, 0, 4, 0, 4'h5);
      vecs[13] = mk(0, 1, 4'h6, 1, 4'h7, 1,  0, 1, 0, 4, 0, 4'h5);
      vecs[14] = mk(0, 1, 4'h6, 1, 4'h7, 1,  0, 0, 1, 5, 0, 4'h5);
      vecs[15] = mk(0, 1, 4'h6, 1, 4'h7, 1,  1, 0, 0, 4, 1, 4'hA);
      vecs[16] = mk(0, 1, 4'h6, 1, 4'h7, 1,  0, 0, 1, 5, 0, 4'hA);
      vecs[17] = mk(0, 1, 4'h6, 1, 4'h7, 1,  0, 1, 0, 4, 1, 4'hB);
      vecs[18] = mk(0, 1, 4'h6, 1, 4'h7, 1,  0, 0, 1, 5, 0, 4'hB);
      vecs[19] = mk(0, 0, 4'h0, 0, 4'h0, 0,  0, 0, 0, 4, 1, 4'hC);

      rst = 1'b1; wr0_req = 0; wr1_req = 0; rd_req = 0; wr0_data = 0; wr1_data = 0;
      @(posedge clk); #1;
      m_reset();
      step(1, 0, 0, 0, 0, 0);
      chk("reset_empty", 32'(empty), 32'd1);
      chk("reset_full", 32'(full), 32'd0);

      for (int i = 0; i < 20; i++) begin
         step(vecs[i].r, vecs[i].w0r, vecs[i].w0d, vecs[i].w1r, vecs[i].w1d, vecs[i].rr);
         chk($sformatf("vec%0d_g0", i), 32'(s_g0), 32'(vecs[i].g0));
         chk($sformatf("vec%0d_g1", i), 32'(s_g1), 32'(vecs[i].g1));
         chk($sformatf("vec%0d_gr", i), 32'(s_gr), 32'(vecs[i].gr));
         chk($sformatf("vec%0d_cnt", i), 32'(s_cnt), 32'(vecs[i].cnt));
         chk($sformatf("vec%0d_dv", i), 32'(s_dv), 32'(vecs[i].dv));
         chk($sformatf("vec%0d_dout", i), 32'(s_dout), 32'(vecs[i].dout));
      end

      // Fill to full, blocked 17th push, then drain in order.
      step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++) step(0, 1, 4'(i), 0, 0, 0);
      step(0, 1, 4'h9, 0, 0, 0);
      chk("full_at_16", 32'(full), 32'd1);
      chk("no_gnt_when_full", 32'(s_g0), 32'd0);
      chk("count_16", 32'(s_cnt), 32'd16);
      for (int i = 0; i < 16; i++) begin
         step(0, 0, 0, 0, 0, 1);
         chk("pop_gnt", 32'(s_gr), 32'd1);
         if (i > 0) begin
            chk("pop_dv", 32'(s_dv), 32'd1);
            chk("pop_data", 32'(s_dout), 32'(i - 1));
         end
      end
      step(0, 0, 0, 0, 0, 0);
      chk("last_pop_data", 32'(s_dout), 32'hF);
      chk("drained_empty", 32'(empty), 32'd1);

      // Pointer wrap: push 12, pop 12, push 8, pop 8.
      for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 4'(i + 3), 0);
      for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 4'(15 - i), 0);
      for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0);
      chk("wrap_last_data", 32'(s_dout), 32'h8);
      chk("wrap_count0", 32'(s_cnt), 32'd0);

      // Reset colliding with a grant at count 5.
      for (int i = 0; i < 5; i++) step(0, 1, 4'(i + 1), 0, 0, 0);
      step(1, 1, 4'hE, 0, 0, 0);
      chk("rst_cycle_gnt", 32'(s_g0), 32'd1);
      step(0, 0, 0, 0, 0, 0);
      chk("rst_count0", 32'(s_cnt), 32'd0);
      chk("rst_no_dv", 32'(s_dv), 32'd0);
      chk("rst_dout0", 32'(s_dout), 32'd0);

      // Randomized traffic with phases biased toward filling or draining.
      for (int i = 0; i < 3000; i++) begin
         int pw, pr;
         pw = ((i / 300) % 3 == 0) ? 80 : ((i / 300) % 3 == 1) ? 20 : 50;
         pr = 100 - pw;
         step($urandom_range(0, 99) == 0,
              $urandom_range(0, 99) < pw, 4'($urandom),
              $urandom_range(0, 99) < pw, 4'($urandom),
              $urandom_range(0, 99) < pr);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_arb_ctrl.md
FIFO_ARB_CTRL -- requirements
Module: fifo_arb_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset, sampled on the clk rising edge.
REQ-002 The block SHALL have the following requester ports:
- wr0_req  input  1  writer 0 requests a push.
- wr0_data  input  4  writer 0 push data.
- wr0_gnt  output  1  writer 0 push accepted this cycle (combinational).
- wr1_req  input  1  writer 1 requests a push.
- wr1_data  input  4  writer 1 push data.
- wr1_gnt  output  1  writer 1 push accepted this cycle (combinational).
- rd_req  input  1  reader requests a pop.
- rd_gnt  output  1  pop accepted this cycle (combinational).
REQ-003 The block SHALL have the following data and status ports:
- data_out  output  4  last popped word (registered).
- data_valid  output  1  one-cycle pulse; data_out updated this cycle.
- full  output  1  count == 16.
- empty  output  1  count == 0.
- count  output  5  occupancy, 0..16.

Function
REQ-004 Storage SHALL be 16 entries x 4 bits, with 4-bit wr_ptr and rd_ptr that wrap 15 -> 0, and a 5-bit count so that all 16 entries are usable.
REQ-005 At most one storage operation (push or pop) SHALL occur per cycle, and at most one of wr0_gnt, wr1_gnt and rd_gnt SHALL be 1 in any cycle.
REQ-006 Eligibility: W0 = wr0_req && !full; W1 = wr1_req && !full; R = rd_req && !empty.
REQ-007 The FSM register last_op SHALL take one of the states IDLE, WR0, WR1, RD, and SHALL update each cycle to the granted operation, or to IDLE if nothing is granted.
REQ-008 A 1-bit last_wr register SHALL record the most recently granted writer (0 or 1) and SHALL hold its value when no write is granted.
REQ-009 Read/write selection:
- If R and (W0 or W1) are both eligible, the read SHALL win when last_op is WR0 or WR1, and a write SHALL win when last_op is IDLE or RD.
- If only one class is eligible, that class SHALL win.
REQ-010 Writer selection: if W0 and W1 are both eligible and a write wins, the writer != last_wr SHALL be granted; otherwise the single eligible writer SHALL be granted.
REQ-011 On a granted push, mem[wr_ptr] SHALL take the granted writer's data, wr_ptr SHALL increment and count SHALL increment, all at the same clk edge.
REQ-012 On a granted pop, data_out SHALL take mem[rd_ptr] and data_valid SHALL be 1 in the following cycle (one-cycle latency), and rd_ptr SHALL increment and count SHALL decrement.
REQ-013 data_out SHALL hold its value between pops, and data_valid SHALL be 0 in every cycle not following a pop.
REQ-014 Requests not granted SHALL be ignored, with no queuing; the requester SHALL hold its req and data until it sees gnt.
REQ-015 When full, no write grant SHALL be issued even if R is not eligible, and the write requests SHALL be stalled.
REQ-016 When empty, rd_gnt SHALL be 0, and no data_valid SHALL be produced.
REQ-017 full, empty and count SHALL be combinational from registered state only; gnt outputs SHALL depend on the req inputs and registered state only.
REQ-018 count SHALL never exceed 16 or go below 0 under any input sequence.

Reset
REQ-019 When rst=1 at a clk edge, the block SHALL clear wr_ptr, rd_ptr, count and data_out to 0, set data_valid to 0, last_op to IDLE and last_wr to 1.
REQ-020 After reset, empty SHALL be 1, full SHALL be 0, and all gnt outputs SHALL be 0 until requests arrive; memory contents are not reset.
REQ-021 Reset asserted mid-operation SHALL override any grant in that cycle, and no push or pop SHALL take effect.
REQ-022 On the first cycle after reset, if W0 and W1 are both eligible, W0 SHALL win because last_wr=1.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Reset, then wr0_req with data 4'h3 and wr1_req with data 4'h5 held for 2 cycles -> wr0_gnt then wr1_gnt; count 0 -> 1 -> 2.
- Push 16 words 0..F via wr0 -> full=1 at count=16, and wr0_gnt stays 0 on the 17th request; then 16 pops -> data_out 0..F, each with a data_valid pulse one cycle after rd_gnt; empty=1 at the end.
- From count=4, hold wr0_req, wr1_req and rd_req for 6 cycles -> grant order alternates write/read with writers rotating: W1, R, W0, R, W1, R (given last_wr=0 at start); count ends at 4.
- Wrap-around: push 12, pop 12, push 8, pop 8 -> data matches push order across the ptr wrap 15 -> 0, and count is 0 at the end.
- rd_req with count=0 -> rd_gnt=0, data_valid=0, and data_out unchanged.
- Assert rst in the same cycle as wr0_gnt at count=5 -> count=0 next cycle, with no push and no data_valid.
